// File: rtl/decode_hazard_ctrl.sv
// Hazard sequencer for the fetch/decode pipeline registers: turns load-use,
// multi-cycle busy, mispredict and serializing conditions into stall/flush controls.
module decode_hazard_ctrl #(
    parameter int unsigned REDIRECT_CYCLES = 1,
    parameter int unsigned CNT_W           = 32
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             valid_de_i,
    input  logic [4:0]       rs1_de_i,
    input  logic [4:0]       rs2_de_i,
    input  logic             serialize_de_i,
    input  logic             valid_ex_i,
    input  logic [4:0]       rd_ex_i,
    input  logic             load_ex_i,
    input  logic             mc_busy_ex_i,
    input  logic             valid_mem_i,
    input  logic             valid_wb_i,
    input  logic             mispredict_ex_i,
    output logic             stall_fi_o,
    output logic             stall_de_o,
    output logic             stall_ex_o,
    output logic             flush_de_o,
    output logic             flush_ex_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        RUN,
        MC_WAIT,
        DRAIN,
        REDIRECT
    } state_t;

    localparam logic [2:0] REDIR_LOAD = 3'(REDIRECT_CYCLES);
    localparam state_t     MISP_NEXT  = (REDIRECT_CYCLES > 0) ? REDIRECT : RUN;

    state_t           state_q, state_d;
    logic [2:0]       redir_q, redir_d;
    logic [CNT_W-1:0] stall_cnt_q;

    logic load_use;
    logic drained;
    logic ser_pending;

    assign load_use = load_ex_i & valid_ex_i & valid_de_i & (rd_ex_i != 5'd0) &
                      ((rd_ex_i == rs1_de_i) | (rd_ex_i == rs2_de_i));
    assign drained  = ~valid_ex_i & ~valid_mem_i & ~valid_wb_i;

    // A serializing instruction stays parked until the pipeline behind it is
    // empty; once in DRAIN the held decode register keeps it pending.
    assign ser_pending = ((serialize_de_i & valid_de_i) | (state_q == DRAIN)) & ~drained;

    always_comb begin
        // NOTE: every output and next-state term gets a default first so no
        // branch below can leave one unassigned and infer a latch.
        stall_fi_o = 1'b0;
        stall_de_o = 1'b0;
        stall_ex_o = 1'b0;
        flush_de_o = 1'b0;
        flush_ex_o = 1'b0;
        state_d    = state_q;
        redir_d    = redir_q;

        if (!reset_n_i) begin
            flush_de_o = 1'b1;
            flush_ex_o = 1'b1;
        end else if (mispredict_ex_i) begin
            flush_de_o = 1'b1;
            flush_ex_o = 1'b1;
            state_d    = MISP_NEXT;
            redir_d    = REDIR_LOAD;
        end else if (state_q == REDIRECT) begin
            flush_de_o = 1'b1;
            redir_d    = redir_q - 3'd1;
            if (redir_q <= 3'd1) begin
                state_d = RUN;
            end
        end else if (mc_busy_ex_i) begin
            stall_fi_o = 1'b1;
            stall_de_o = 1'b1;
            stall_ex_o = 1'b1;
            state_d    = MC_WAIT;
        end else if (load_use || ser_pending) begin
            // Hold fetch/decode and let execute take a bubble.
            stall_fi_o = 1'b1;
            stall_de_o = 1'b1;
            flush_ex_o = 1'b1;
            state_d    = ser_pending ? DRAIN : RUN;
        end else begin
            state_d = RUN;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= RUN;
            redir_q     <= 3'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            redir_q <= redir_d;
            if (stall_de_o) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: doc/decode_hazard_ctrl.md
Name: decode_hazard_ctrl

Overview:
- Sequences the fetch/decode pipeline registers: generates stall_fi/stall_de/flush_de/flush_ex for the decode stage register and the execute register that follows it.
- Resolves four hazard classes: load-use, multi-cycle execute unit busy, branch mispredict redirect, and serializing instructions (CSR writes/FENCE) that must wait for a drained pipeline.
- Registered FSM plus a redirect counter and a stall-cycle performance counter. Sits beside decode_stage in the core top level.

Parameters:
- REDIRECT_CYCLES, 1, extra cycles flush_de_o stays high after a mispredict (fetch refill latency); legal range 0..7.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk_i  in  1  core clock
- reset_n_i  in  1  asynchronous active-low reset
- valid_de_i  in  1  decode register holds a real instruction
- rs1_de_i  in  5  decode source register 1
- rs2_de_i  in  5  decode source register 2
- serialize_de_i  in  1  decode instruction is serializing (CSR write, FENCE)
- valid_ex_i  in  1  execute stage valid
- rd_ex_i  in  5  execute destination register
- load_ex_i  in  1  execute instruction is a load
- mc_busy_ex_i  in  1  multi-cycle unit in execute is not done
- valid_mem_i  in  1  memory stage valid
- valid_wb_i  in  1  writeback stage valid
- mispredict_ex_i  in  1  branch resolved opposite to prediction (or target mismatch) in execute
- stall_fi_o  out  1  hold PC/fetch
- stall_de_o  out  1  hold decode register
- stall_ex_o  out  1  hold execute register
- flush_de_o  out  1  clear decode register
- flush_ex_o  out  1  clear/bubble execute register
- stall_cnt_o  out  CNT_W  cycles with stall_de_o=1

Behaviour:
- Reset (reset_n_i=0, asynchronous): state=RUN, redirect counter=0, stall_cnt_o=0. While reset is low: flush_de_o=flush_ex_o=1 and all stalls=0.
- Outputs are combinational from the registered state and the current inputs. State updates on the rising clk_i edge.
- load_use = load_ex_i & valid_ex_i & valid_de_i & (rd_ex_i!=0) & (rd_ex_i==rs1_de_i | rd_ex_i==rs2_de_i).
- drained = ~valid_ex_i & ~valid_mem_i & ~valid_wb_i.
- States: RUN, MC_WAIT, DRAIN, REDIRECT.
- Priority, highest first: mispredict, mc_busy, load_use, serialize.
- mispredict_ex_i=1 in any state:
  - flush_de_o=1, flush_ex_o=1, all stalls=0.
  - Next state is REDIRECT with counter=REDIRECT_CYCLES if REDIRECT_CYCLES>0, otherwise RUN.
- REDIRECT: flush_de_o=1, stalls=0. Counter decrements each cycle. Exit to RUN in the cycle the counter reads 1. A new mispredict reloads the counter.
- mc_busy_ex_i=1 (no mispredict):
  - stall_fi_o=stall_de_o=stall_ex_o=1, flush=0.
  - State MC_WAIT while busy. Return to RUN on the first cycle busy=0; in that cycle the normal RUN rules apply.
- load_use (RUN, no mispredict/busy): stall_fi_o=stall_de_o=1, flush_ex_o=1 (one bubble). Lasts exactly one cycle because the load advances.
- serialize_de_i & valid_de_i & ~drained (RUN): stall_fi_o=stall_de_o=1, flush_ex_o=1, state→DRAIN.
- DRAIN: same outputs every cycle until drained=1. In that cycle stalls=0 and the instruction issues. The FSM returns to RUN and does not re-enter DRAIN for the same instruction, because the decode register advances.
- serialize with drained already true: no stall.
- Mispredict during DRAIN or MC_WAIT: the mispredict wins and the serializing instruction is flushed.
- stall_cnt_o increments when stall_de_o=1. It wraps modulo 2^CNT_W and is not cleared by flushes.
- rs=0 never creates a load-use hazard. valid_de_i=0 never stalls.

Test Plan:
1. Reset: hold reset_n_i=0 for 3 cycles mid-stream → flush_de_o=flush_ex_o=1, stalls=0, stall_cnt_o=0. Release → RUN with all outputs 0 when no hazard is present.
2. Load-use: load_ex_i=1, rd_ex_i=5, rs2_de_i=5, valid_de_i=1 → exactly 1 cycle of stall_fi_o=stall_de_o=flush_ex_o=1, stall_cnt_o=1. Repeat with rd_ex_i=0 → no stall.
3. Multi-cycle: mc_busy_ex_i high for 4 cycles → all three stalls high for 4 cycles, stall_cnt_o+=4. Same-cycle load_use is ignored while busy.
4. Mispredict with REDIRECT_CYCLES=2: pulse mispredict_ex_i → flush_de_o high for 3 cycles and flush_ex_o high for 1, then RUN. A second mispredict in the 2nd cycle extends flush_de_o by 2 more cycles.
5. Serialize: serialize_de_i=1 with valid_mem_i=1 and valid_wb_i=1 draining over 3 cycles → stalls high until drained, then one issue cycle with stalls=0, state RUN.
6. Precedence: mispredict_ex_i=1 while in DRAIN with mc_busy_ex_i=1 → flush_de_o=flush_ex_o=1, stalls=0, next state REDIRECT.
